dadda_dot_acc: RTL and testbench



---
 rtl/dadda_dot_acc_pkg.sv | 14 +
 rtl/dadda_dot_acc_add.sv | 27 ++
 rtl/dadda_dot_acc.sv | 101 ++++++++++
 tb/tb_dadda_dot_acc.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/dadda_dot_acc_pkg.sv
// Shared types and constants for the Dadda product-stream dot-product accumulator.
package dadda_dot_acc_pkg;

    localparam int unsigned PROD_W    = 16;
    localparam int unsigned ACC_W_DEF = 24;
    localparam int unsigned CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/dadda_dot_acc_add.sv
// Accumulator adder (ACC_W+1 bits); DADDA_DOT_ACC_SAT_EN clamps on carry-out instead of wrapping.
module dadda_dot_acc_add
    import dadda_dot_acc_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] p_data,
    output logic [ACC_W-1:0]  sum_c,
    output logic              ovf_c
);

    localparam int unsigned SUM_W = ACC_W + 1;

    logic [SUM_W-1:0] wide_c;

    assign wide_c = {1'b0, acc} + SUM_W'(p_data);
    assign ovf_c  = wide_c[ACC_W];

`ifdef DADDA_DOT_ACC_SAT_EN
    // Once clamped, every further nonzero beat carries again, so acc stays all-ones.
    assign sum_c = ovf_c ? '1 : wide_c[ACC_W-1:0];
`else
    assign sum_c = wide_c[ACC_W-1:0];
`endif

endmodule

// File: rtl/dadda_dot_acc.sv
// Packet-delimited accumulator for the Dadda product stream; result held until handshake.
// Optional saturation via DADDA_DOT_ACC_SAT_EN (inside dadda_dot_acc_add).
module dadda_dot_acc
    import dadda_dot_acc_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p_valid,
    output logic              p_ready,
    input  logic [15:0]       p_data,
    input  logic              p_last,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic [ACC_W-1:0]  acc_data,
    output logic [CNT_W-1:0]  acc_cnt,
    output logic              acc_ovf
);

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             p_ready_q, p_ready_d;
    logic             acc_valid_q, acc_valid_d;
    logic [ACC_W-1:0] add_sum_c;
    logic             add_ovf_c;
    logic             beat_c;

    dadda_dot_acc_add #(.ACC_W(ACC_W)) u_add (
        .acc    (acc_q),
        .p_data (p_data),
        .sum_c  (add_sum_c),
        .ovf_c  (add_ovf_c)
    );

    assign beat_c = p_valid && p_ready_q;

    // Next-state and datapath update; handshake flags follow the next state.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (beat_c) begin
                    acc_d   = ACC_W'(p_data);
                    cnt_d   = CNT_W'(1);
                    ovf_d   = 1'b0;
                    state_d = p_last ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (beat_c) begin
                    acc_d = add_sum_c;
                    cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
                    ovf_d = ovf_q | add_ovf_c;
                    if (p_last) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (acc_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        p_ready_d   = (state_d != HOLD);
        acc_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            p_ready_q   <= 1'b1;
            acc_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            p_ready_q   <= p_ready_d;
            acc_valid_q <= acc_valid_d;
        end
    end

    assign p_ready   = p_ready_q;
    assign acc_valid = acc_valid_q;
    assign acc_data  = acc_q;
    assign acc_cnt   = cnt_q;
    assign acc_ovf   = ovf_q;

endmodule

// File: tb/tb_dadda_dot_acc.sv
// Bench for dadda_dot_acc: two instances (ACC_W=24 and ACC_W=17) share one stimulus
// stream and are checked against an integer reference of the packet sum.
module tb_dadda_dot_acc;

    localparam int unsigned WA = 24;
    localparam int unsigned WB = 17;
    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          p_valid = 1'b0;
    logic          p_last = 1'b0;
    logic          acc_ready = 1'b0;
    logic [15:0]   p_data = '0;

    logic          a_p_ready, a_acc_valid, a_acc_ovf;
    logic [WA-1:0] a_acc_data;
    logic [CW-1:0] a_acc_cnt;
    logic          b_p_ready, b_acc_valid, b_acc_ovf;
    logic [WB-1:0] b_acc_data;
    logic [CW-1:0] b_acc_cnt;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int unsigned bq[$];

    always #5 clk = ~clk;

    dadda_dot_acc #(.ACC_W(WA), .CNT_W(CW)) u_a (
        .clk(clk), .rst_n(rst_n), .p_valid(p_valid), .p_ready(a_p_ready),
        .p_data(p_data), .p_last(p_last), .acc_valid(a_acc_valid),
        .acc_ready(acc_ready), .acc_data(a_acc_data), .acc_cnt(a_acc_cnt),
        .acc_ovf(a_acc_ovf)
    );

    dadda_dot_acc #(.ACC_W(WB), .CNT_W(CW)) u_b (
        .clk(clk), .rst_n(rst_n), .p_valid(p_valid), .p_ready(b_p_ready),
        .p_data(p_data), .p_last(p_last), .acc_valid(b_acc_valid),
        .acc_ready(acc_ready), .acc_data(b_acc_data), .acc_cnt(b_acc_cnt),
        .acc_ovf(b_acc_ovf)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: true integer sum of the packet, then wrapped or clamped to w bits.
    function automatic logic [63:0] ref_sum(input int unsigned beats[$], input int unsigned w);
        longint unsigned s = 0;
        longint unsigned lim = (64'd1 << w) - 64'd1;
        foreach (beats[i]) s += longint'(beats[i]);
`ifdef DADDA_DOT_ACC_SAT_EN
        return (s > lim) ? lim : s;
`else
        return s & lim;
`endif
    endfunction

    function automatic logic [63:0] ref_ovf(input int unsigned beats[$], input int unsigned w);
        longint unsigned s = 0;
        foreach (beats[i]) s += longint'(beats[i]);
        return (s > ((64'd1 << w) - 64'd1)) ? 64'd1 : 64'd0;
    endfunction

    function automatic logic [63:0] ref_cnt(input int unsigned beats[$]);
        return (beats.size() > 255) ? 64'd255 : 64'(beats.size());
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag, input int unsigned beats[$]);
        check({tag, "_valid_a"}, 64'(a_acc_valid), 64'd1);
        check({tag, "_valid_b"}, 64'(b_acc_valid), 64'd1);
        check({tag, "_data_a"}, 64'(a_acc_data), ref_sum(beats, WA));
        check({tag, "_data_b"}, 64'(b_acc_data), ref_sum(beats, WB));
        check({tag, "_cnt_a"}, 64'(a_acc_cnt), ref_cnt(beats));
        check({tag, "_cnt_b"}, 64'(b_acc_cnt), ref_cnt(beats));
        check({tag, "_ovf_a"}, 64'(a_acc_ovf), ref_ovf(beats, WA));
        check({tag, "_ovf_b"}, 64'(b_acc_ovf), ref_ovf(beats, WB));
    endtask

    // Drive beats with random idle gaps; last beat carries p_last when close is set.
    task automatic send_packet(input int unsigned beats[$], input int unsigned max_gap, input bit close);
        int  tries;
        bit  ok;
        for (int i = 0; i < beats.size(); i++) begin
            repeat ((max_gap != 0) ? $urandom_range(0, max_gap) : 0) step();
            p_valid = 1'b1;
            p_data  = 16'(beats[i]);
            p_last  = close && (i == beats.size() - 1);
            tries = 0;
            ok    = 1'b0;
            while (!ok && tries < 20) begin
                ok = a_p_ready;
                step();
                tries++;
            end
            if (!ok) check("accept_timeout", 64'd0, 64'd1);
            p_valid = 1'b0;
            p_last  = 1'b0;
        end
    endtask

    task automatic release_result(input string tag);
        acc_ready = 1'b1;
        step();
        acc_ready = 1'b0;
        check({tag, "_rel_valid"}, 64'(a_acc_valid), 64'd0);
        check({tag, "_rel_ready"}, 64'({a_p_ready, b_p_ready}), 64'd3);
    endtask

    task automatic fill(input int unsigned v, input int n);
        bq.delete();
        for (int i = 0; i < n; i++) bq.push_back(v);
    endtask

    initial begin
        #12;
        check("rst_p_ready", 64'({a_p_ready, b_p_ready}), 64'd3);
        check("rst_acc_valid", 64'({a_acc_valid, b_acc_valid}), 64'd0);
        check("rst_acc_data", 64'(a_acc_data), 64'd0);
        check("rst_acc_cnt", 64'(a_acc_cnt), 64'd0);
        check("rst_acc_ovf", 64'({a_acc_ovf, b_acc_ovf}), 64'd0);
        rst_n = 1'b1;
        step();

        fill(65025, 1);
        send_packet(bq, 0, 1'b1);
        check_outputs("single", bq);
        release_result("single");

        fill(65025, 4);
        send_packet(bq, 0, 1'b1);
        check_outputs("four", bq);
        release_result("four");

        fill(65025, 3);
        send_packet(bq, 0, 1'b1);
        check_outputs("three", bq);
        release_result("three");

        // Result held while a new beat waits; the waiting beat opens the next packet.
        bq.delete(); bq.push_back(1); bq.push_back(2);
        send_packet(bq, 0, 1'b1);
        p_valid = 1'b1; p_data = 16'd9; p_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_p_ready", 64'({a_p_ready, b_p_ready}), 64'd0);
            check_outputs("hold", bq);
        end
        acc_ready = 1'b1;
        step();
        acc_ready = 1'b0;
        check("bubble_p_ready", 64'(a_p_ready), 64'd1);
        check("bubble_valid", 64'(a_acc_valid), 64'd0);
        step();
        p_valid = 1'b0; p_last = 1'b0;
        fill(9, 1);
        check_outputs("queued", bq);
        release_result("queued");

        // acc_ready held high while the packet is open must not disturb it.
        bq.delete(); bq.push_back(3); bq.push_back(5); bq.push_back(7);
        for (int r = 0; r < 3; r++) begin
            acc_ready = 1'b1;
            send_packet(bq, 3, 1'b1);
            check_outputs("gaps", bq);
            release_result("gaps");
        end

        fill(100, 2);
        send_packet(bq, 0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 64'({a_p_ready, b_p_ready}), 64'd3);
        check("mid_rst_valid", 64'({a_acc_valid, b_acc_valid}), 64'd0);
        check("mid_rst_data", 64'(a_acc_data), 64'd0);
        check("mid_rst_cnt", 64'(a_acc_cnt), 64'd0);
        check("mid_rst_ovf", 64'(a_acc_ovf), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        fill(7, 1);
        send_packet(bq, 0, 1'b1);
        check_outputs("post_rst", bq);
        release_result("post_rst");

        for (int k = 0; k < 20; k++) begin
            int n;
            n = $urandom_range(1, 6);
            bq.delete();
            for (int i = 0; i < n; i++)
                bq.push_back(($urandom_range(0, 1) != 0) ? $urandom_range(60000, 65535) : $urandom_range(0, 65535));
            send_packet(bq, 2, 1'b1);
            check_outputs("random", bq);
            release_result("random");
        end

        fill(1, 300);
        send_packet(bq, 0, 1'b1);
        check_outputs("cnt_sat", bq);
        release_result("cnt_sat");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
